prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program/data loader. It is the write-side counterpart of the bench-side memory/register dump.
- Receives a framed byte stream over a valid/ready interface, assembles little-endian 32-bit words, and writes them into the CPU instruction memory or data memory.
- Holds the CPU stalled (cpu_hold) until a GO command arrives.
- Sits in top between an external byte source (UART receiver or bench driver) and the imem/dmem write ports.

Parameters:
- ADDR_W, 8, word-address width of the memory write port; addresses wrap modulo 2^ADDR_W.
- CNT_W, 8, width of the word-count header byte field (fixed at 8 by the frame format).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte source has a byte.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid & in_ready at a clk edge.
- mem_we  out  1  one-cycle write strobe.
- mem_sel  out  1  0 = instruction memory, 1 = data memory.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- cpu_hold  out  1  1 = CPU stalled or held.
- busy  out  1  frame in progress (states HDR_BASE, HDR_CNT, LOAD).
- err  out  1  sticky illegal-command flag.
- words_loaded  out  ADDR_W+1  words written since the last LOAD command header.

Behaviour:
- Reset (async, rst_n=0). State=IDLE. Outputs: cpu_hold=1, in_ready=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, busy=0, err=0, words_loaded=0. in_ready rises on the first edge after reset release.
- in_ready is 1 in every state except during reset. The loader never back-pressures; the write is registered and takes one cycle.
- Command bytes:
  - LD_I=0xA5: load imem.
  - LD_D=0x5A: load dmem.
  - GO=0x3C: release hold.
  - HALT=0xC3: reassert hold.
- IDLE: accepted byte is decoded as follows.
  - LD_I or LD_D: latch mem_sel, clear words_loaded, go to HDR_BASE.
  - GO: cpu_hold<=0, go to RUN.
  - Any other byte: err<=1, stay in IDLE.
- HDR_BASE: accepted byte is the base word address (zero-extended/truncated to ADDR_W). Go to HDR_CNT.
- HDR_CNT: accepted byte is the word count N.
  - N=0: return to IDLE with no writes.
  - Otherwise: byte index=0, go to LOAD.
- LOAD: each accepted byte is shifted into the word buffer, little-endian (first byte -> bits 7:0).
  - On the 4th byte handshake: at the next edge, mem_we=1 for exactly one cycle, mem_addr=base+k (mod 2^ADDR_W), mem_wdata=assembled word, words_loaded increments.
  - After the N-th word strobe: return to IDLE.
  - Write latency is exactly 1 cycle after the 4th byte handshake.
  - Back-to-back bytes sustain one word per 4 cycles. Gaps with in_valid=0 pause assembly without losing partial bytes.
- RUN: cpu_hold=0.
  - HALT: cpu_hold<=1, go to IDLE.
  - Any other byte: accepted and dropped; no err.
- err is sticky; it is cleared only by reset.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Reset mid-LOAD: the partial word is discarded, no strobe is issued, and hold is reasserted.
- Simultaneous events: at most one byte per cycle. A command byte arriving in the same cycle as the mem_we strobe is handled normally; decode and strobe are independent.

Decomposition:
- Package prog_loader_pkg:
  - Command constants LD_I, LD_D, GO, HALT.
  - State enum IDLE, HDR_BASE, HDR_CNT, LOAD, RUN.
- Sub-module: word_assembler. Holds the 2-bit byte index and the 32-bit shift buffer, and produces word_done plus the word. The FSM and address counter stay in prog_loader.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-stream -> all outputs take their reset values immediately (async). After release, cpu_hold=1 and in_ready=1.
- imem load: stream A5 10 02 78 56 34 12 EF BE AD DE -> two writes: mem_sel=0, (addr 0x10, 0x12345678), then (addr 0x11, 0xDEADBEEF). Each mem_we is 1 cycle, 1 cycle after the 4th byte. words_loaded=2, state returns to IDLE.
- dmem load with wrap and gaps: ADDR_W=8, stream 5A FF 02 then 8 data bytes with random in_valid gaps -> writes land at addr 0xFF then 0x00 with mem_sel=1; no partial word is lost.
- Zero count and illegal command: A5 00 00 -> no mem_we. Then byte 0x77 -> err=1 and stays 1. A following valid frame still loads correctly.
- GO/HALT: 3C -> cpu_hold falls 1 cycle later. Bytes A5 11 in RUN produce no writes and no err. C3 -> cpu_hold=1 and the FSM is back in IDLE, accepting a new load.
- Reset mid-LOAD: after A5 00 01 AA BB, assert rst_n=0 -> no mem_we ever pulses. After release, a fresh frame writes correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared command codes and FSM state encoding for the program loader.
package prog_loader_pkg;

  localparam logic [7:0] LD_I = 8'hA5;
  localparam logic [7:0] LD_D = 8'h5A;
  localparam logic [7:0] GO   = 8'h3C;
  localparam logic [7:0] HALT = 8'hC3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_BASE = 3'd1,
    HDR_CNT  = 3'd2,
    LOAD     = 3'd3,
    RUN      = 3'd4
  } state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Little-endian byte-to-word assembler: byte index plus shift buffer.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  in_data,
  output logic        word_done,
  output logic [31:0] word
);

  // Only the first three bytes need storage; the fourth is taken straight
  // from in_data so the word is complete in the handshake cycle itself.
  logic [1:0]  idx;
  logic [23:0] buf_q;

  assign word_done = shift_en && (idx == 2'd3);
  assign word      = {in_data, buf_q};

  // Byte index and shift buffer; first byte ends up in bits 7:0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= 2'd0;
      buf_q <= 24'd0;
    end else if (clear) begin
      idx   <= 2'd0;
      buf_q <= 24'd0;
    end else if (shift_en) begin
      idx   <= idx + 2'd1;
      buf_q <= {in_data, buf_q[23:8]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing 32-bit words into imem/dmem and
// gating the CPU with cpu_hold until a GO command.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for a command byte, CPU held
// HDR_BASE | next byte is the base word address
// HDR_CNT  | next byte is the word count (0 aborts the frame)
// LOAD     | assembling data bytes, one write per 4 bytes
// RUN      | CPU released; only HALT is acted upon
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state, state_nxt;
  logic              accept;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  remain;

  logic do_ld, do_go, do_halt, set_err, do_base, do_cnt, do_write;
  logic asm_clear, asm_shift, word_done;
  logic [31:0] asm_word;

  assign accept = in_valid && in_ready;
  assign busy   = (state == HDR_BASE) || (state == HDR_CNT) || (state == LOAD);

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .in_data   (in_data),
    .word_done (word_done),
    .word      (asm_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    do_ld     = 1'b0;
    do_go     = 1'b0;
    do_halt   = 1'b0;
    set_err   = 1'b0;
    do_base   = 1'b0;
    do_cnt    = 1'b0;
    do_write  = 1'b0;
    asm_clear = 1'b0;
    asm_shift = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (in_data == LD_I || in_data == LD_D) begin
          do_ld     = 1'b1;
          state_nxt = HDR_BASE;
        end else if (in_data == GO) begin
          do_go     = 1'b1;
          state_nxt = RUN;
        end else begin
          set_err   = 1'b1;
        end
      end
      HDR_BASE: if (accept) begin
        do_base   = 1'b1;
        state_nxt = HDR_CNT;
      end
      HDR_CNT: if (accept) begin
        if (in_data == 8'h00) begin
          state_nxt = IDLE;
        end else begin
          do_cnt    = 1'b1;
          asm_clear = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        asm_shift = accept;
        if (word_done) begin
          do_write = 1'b1;
          if (remain == CNT_W'(1)) state_nxt = IDLE;
        end
      end
      RUN: if (accept && in_data == HALT) begin
        do_halt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake, hold and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      cpu_hold <= 1'b1;
      err      <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      if (do_go)   cpu_hold <= 1'b0;
      if (do_halt) cpu_hold <= 1'b1;
      if (set_err) err      <= 1'b1;
    end
  end

  // Frame header latches, word-count down-counter and memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_sel      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      words_loaded <= '0;
      wr_addr      <= '0;
      remain       <= '0;
    end else begin
      mem_we <= do_write;
      if (do_ld) begin
        mem_sel      <= (in_data == LD_D);
        words_loaded <= '0;
      end
      if (do_base) wr_addr <= ADDR_W'(in_data);
      if (do_cnt)  remain  <= CNT_W'(in_data);
      if (do_write) begin
        mem_addr     <= wr_addr;
        mem_wdata    <= asm_word;
        wr_addr      <= wr_addr + ADDR_W'(1);
        remain       <= remain - CNT_W'(1);
        words_loaded <= words_loaded + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame table plus a write scoreboard.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        err;
  logic [8:0]  words_loaded;

  prog_loader #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] data;
    int          ncyc;
  } wr_t;

  typedef struct {
    logic        pre_en;
    logic [7:0]  pre_byte;
    logic [7:0]  cmd;
    logic [7:0]  base;
    logic [7:0]  cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        gaps;
    logic        exp_sel;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [8:0]  exp_wl;
    logic        exp_err;
  } vec_t;

  wr_t  sbq[$];
  wr_t  got;
  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;
  int   neg_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends one word little-endian and registers the write it must cause.
  task automatic send_word(input logic [31:0] w, input logic sel, input logic [7:0] a,
                           input logic gaps);
    wr_t e;
    for (int b = 0; b < 4; b++)
      send(w[8*b +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
    e.sel  = sel;
    e.addr = a;
    e.data = w;
    e.ncyc = neg_cnt + 1;
    sbq.push_back(e);
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    neg_cnt++;
    if (rst_n && mem_we) begin
      chk("we_expected", (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        got = sbq.pop_front();
        chk("wr_sel", mem_sel, got.sel);
        chk("wr_addr", mem_addr, got.addr);
        chk("wr_data", mem_wdata, got.data);
        chk("wr_latency", neg_cnt, got.ncyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'hA5, 8'h10, 8'h02, 32'h12345678, 32'hDEADBEEF, 1'b0,
                1'b0, 8'h10, 8'h11, 9'd2, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 8'h02, 32'hCAFEF00D, 32'h01020304, 1'b1,
                1'b1, 8'hFF, 8'h00, 9'd2, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'hA5, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0,
                1'b0, 8'h00, 8'h00, 9'd0, 1'b0};
    vecs[3] = '{1'b1, 8'h77, 8'h5A, 8'h80, 8'h01, 32'hA1B2C3D4, 32'h0, 1'b0,
                1'b1, 8'h80, 8'h00, 9'd1, 1'b1};

    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_words_loaded", words_loaded, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_cpu_hold", cpu_hold, 1);

    // GO releases hold; loads in RUN are ignored; HALT reasserts hold.
    send(8'h3C, 0);
    chk("go_cpu_hold", cpu_hold, 0);
    send(8'hA5, 0);
    send(8'h11, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    send(8'h04, 0);
    drain();
    chk("run_err", err, 0);
    chk("run_busy", busy, 0);
    chk("run_cpu_hold", cpu_hold, 0);
    send(8'hC3, 0);
    chk("halt_cpu_hold", cpu_hold, 1);
    chk("halt_busy", busy, 0);

    // Frame table.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].pre_en) send(vecs[v].pre_byte, 0);
      send(vecs[v].cmd, 0);
      chk($sformatf("v%0d_busy_hdr", v), busy, 1);
      send(vecs[v].base, 0);
      send(vecs[v].cnt, 0);
      for (int k = 0; k < int'(vecs[v].cnt); k++)
        send_word(k == 0 ? vecs[v].w0 : vecs[v].w1, vecs[v].exp_sel,
                  k == 0 ? vecs[v].a0 : vecs[v].a1, vecs[v].gaps);
      drain();
      chk($sformatf("v%0d_words_loaded", v), words_loaded, vecs[v].exp_wl);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_err", v), err, vecs[v].exp_err);
      if (vecs[v].cnt != 8'h00) begin
        chk($sformatf("v%0d_hold_addr", v), mem_addr, vecs[v].cnt == 8'h02 ? vecs[v].a1 : vecs[v].a0);
        chk($sformatf("v%0d_hold_data", v), mem_wdata, vecs[v].cnt == 8'h02 ? vecs[v].w1 : vecs[v].w0);
      end
    end

    // Command byte accepted in the same cycle as the write strobe.
    send(8'hA5, 0);
    send(8'h20, 0);
    send(8'h01, 0);
    send_word(32'hAABBCCDD, 1'b0, 8'h20, 1'b0);
    send(8'h3C, 0);
    chk("strobe_go_cpu_hold", cpu_hold, 0);
    drain();
    send(8'hC3, 0);
    chk("strobe_halt_cpu_hold", cpu_hold, 1);

    // Reset mid-LOAD: partial word must vanish without a strobe.
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_err", err, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_words_loaded", words_loaded, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    send(8'hA5, 0);
    send(8'h05, 0);
    send(8'h01, 0);
    send_word(32'h11223344, 1'b0, 8'h05, 1'b0);
    drain();
    chk("fresh_words_loaded", words_loaded, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
